keypad_scanner: RTL and testbench

- Front-end for the PIN-entry lock controller. It scans a 4x4 membrane keypad, synchronises and debounces the row inputs, and decodes the pressed key.
- For each debounced press it emits either a one-cycle key_valid pulse with key_value, or a one-cycle cancel pulse.
- It sits directly upstream of the lock FSM and drives that block's key_valid, key_value and cancel inputs.

---
 rtl/keypad_scanner.sv | 191 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 membrane keypad scanner: walks the columns, synchronises and debounces the
// rows, and reports each accepted press as a key_valid or cancel pulse.
module keypad_scanner #(
    parameter int SCAN_DIV        = 250,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic       key_valid,
    output logic [3:0] key_value,
    output logic       cancel,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DEBOUNCE_CYCLES);

    localparam logic [1:0] ST_SCAN         = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
    localparam logic [1:0] ST_EMIT         = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    logic [3:0]       sync1_reg, rs_reg;
    logic [1:0]       state_reg, state_next;
    logic [1:0]       idx_reg, idx_next;
    logic [DIV_W-1:0] div_cnt_reg, div_cnt_next;
    logic [DB_W-1:0]  db_cnt_reg, db_cnt_next;
    logic [3:0]       pat_reg, pat_next;
    logic             key_valid_reg, key_valid_next;
    logic             cancel_reg, cancel_next;
    logic [3:0]       key_value_reg, key_value_next;
    logic             key_held_reg, key_held_next;

    logic [3:0]       rows_low;
    logic             one_low;
    logic [DB_W-1:0]  db_inc;
    logic [DIV_W-1:0] div_inc;
    logic [1:0]       latched_row;

    function automatic logic [1:0] row_of(input logic [3:0] pat);
        case (pat)
            4'b1101: row_of = 2'd1;
            4'b1011: row_of = 2'd2;
            4'b0111: row_of = 2'd3;
            default: row_of = 2'd0;
        endcase
    endfunction

    // Code for (row, col); (3,0) is '*' and is handled as cancel, never as a code.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_code = 4'h1;
            4'h1: key_code = 4'h2;
            4'h2: key_code = 4'h3;
            4'h3: key_code = 4'hA;
            4'h4: key_code = 4'h4;
            4'h5: key_code = 4'h5;
            4'h6: key_code = 4'h6;
            4'h7: key_code = 4'hB;
            4'h8: key_code = 4'h7;
            4'h9: key_code = 4'h8;
            4'hA: key_code = 4'h9;
            4'hB: key_code = 4'hC;
            4'hD: key_code = 4'h0;
            4'hE: key_code = 4'hE;
            4'hF: key_code = 4'hD;
            default: key_code = 4'h0;
        endcase
    endfunction

    assign rows_low    = ~rs_reg;
    assign one_low     = (rows_low != 4'h0) && ((rows_low & (rows_low - 4'h1)) == 4'h0);
    assign db_inc      = db_cnt_reg + DB_W'(1);
    assign div_inc     = div_cnt_reg + DIV_W'(1);
    assign latched_row = row_of(pat_reg);

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        div_cnt_next   = div_cnt_reg;
        db_cnt_next    = db_cnt_reg;
        pat_next       = pat_reg;
        key_valid_next = 1'b0;
        cancel_next    = 1'b0;
        key_value_next = key_value_reg;
        key_held_next  = key_held_reg;

        case (state_reg)
            ST_SCAN: begin
                if (div_cnt_reg == DIV_LAST) begin
                    div_cnt_next = '0;
                    if (one_low) begin
                        pat_next    = rs_reg;
                        db_cnt_next = '0;
                        state_next  = ST_DEBOUNCE;
                    end else begin
                        idx_next = idx_reg + 2'd1;
                    end
                end else begin
                    div_cnt_next = div_inc;
                end
            end
            ST_DEBOUNCE: begin
                if (rs_reg == pat_reg) begin
                    if (db_inc == DB_DONE) begin
                        // Pulses are registered on entry so they are high exactly in EMIT.
                        db_cnt_next   = '0;
                        state_next    = ST_EMIT;
                        key_held_next = 1'b1;
                        if (latched_row == 2'd3 && idx_reg == 2'd0) begin
                            cancel_next = 1'b1;
                        end else begin
                            key_valid_next = 1'b1;
                            key_value_next = key_code(latched_row, idx_reg);
                        end
                    end else begin
                        db_cnt_next = db_inc;
                    end
                end else begin
                    db_cnt_next  = '0;
                    div_cnt_next = '0;
                    idx_next     = idx_reg + 2'd1;
                    state_next   = ST_SCAN;
                end
            end
            ST_EMIT: begin
                db_cnt_next = '0;
                state_next  = ST_WAIT_RELEASE;
            end
            default: begin
                if (rs_reg == 4'hF) begin
                    if (db_inc == DB_DONE) begin
                        db_cnt_next   = '0;
                        div_cnt_next  = '0;
                        idx_next      = idx_reg + 2'd1;
                        key_held_next = 1'b0;
                        state_next    = ST_SCAN;
                    end else begin
                        db_cnt_next = db_inc;
                    end
                end else begin
                    db_cnt_next = '0;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_reg     <= 4'hF;
            rs_reg        <= 4'hF;
            state_reg     <= ST_SCAN;
            idx_reg       <= 2'd0;
            div_cnt_reg   <= '0;
            db_cnt_reg    <= '0;
            pat_reg       <= 4'hF;
            key_valid_reg <= 1'b0;
            cancel_reg    <= 1'b0;
            key_value_reg <= 4'h0;
            key_held_reg  <= 1'b0;
        end else begin
            sync1_reg     <= row_n;
            rs_reg        <= sync1_reg;
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            div_cnt_reg   <= div_cnt_next;
            db_cnt_reg    <= db_cnt_next;
            pat_reg       <= pat_next;
            key_valid_reg <= key_valid_next;
            cancel_reg    <= cancel_next;
            key_value_reg <= key_value_next;
            key_held_reg  <= key_held_next;
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign col_n[gi] = (idx_reg != 2'(gi));
        end
    endgenerate

    assign key_valid = key_valid_reg;
    assign cancel    = cancel_reg;
    assign key_value = key_value_reg;
    assign key_held  = key_held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model shorts rows to driven columns and
// the reported event stream is compared with the sequence of keys pressed.
module tb_keypad_scanner;

    localparam int SD = 4;
    localparam int DB = 8;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] row_n;
    logic [3:0] col_n;
    logic       key_valid;
    logic [3:0] key_value;
    logic       cancel;
    logic       key_held;

    bit pressed [16];
    string keymap = "123A456B789C*0#D";

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    int ev_code[$];
    int ev_cyc[$];
    int both_cnt = 0;
    int consec_cnt = 0;
    bit prev_pulse = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (pressed[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
    end

    keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_CYCLES(DB)) dut (
        .clk(clk), .reset_n(reset_n), .row_n(row_n), .col_n(col_n),
        .key_valid(key_valid), .key_value(key_value), .cancel(cancel), .key_held(key_held)
    );

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (key_valid || cancel) begin
            ev_code.push_back(key_valid ? int'(key_value) : 16);
            ev_cyc.push_back(cyc);
        end
        if (key_valid && cancel) both_cnt = both_cnt + 1;
        if ((key_valid || cancel) && prev_pulse) consec_cnt = consec_cnt + 1;
        prev_pulse = key_valid || cancel;
    end

    // Expected event for key k: its label read as a hex digit, '#' = 0xE, '*' = cancel (16).
    function automatic int code_of(input int k);
        byte ch;
        ch = keymap[k];
        if (ch == "*") return 16;
        if (ch == "#") return 14;
        if (ch >= "0" && ch <= "9") return int'(ch - "0");
        return int'(ch - "A") + 10;
    endfunction

    task automatic press_for(input int k, input int n);
        @(posedge clk); #2 pressed[k] = 1'b1;
        repeat (n) @(posedge clk);
        #2 pressed[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_events();
        ev_code.delete();
        ev_cyc.delete();
        both_cnt = 0;
        consec_cnt = 0;
    endtask

    task automatic test_reset();
        int n;
        bit bad;
        reset_n = 1'b0;
        foreach (pressed[i]) pressed[i] = 1'b0;
        idle(3);
        #1;
        compared++;
        if ({col_n, key_valid, cancel, key_value, key_held} !== {4'b1110, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL reset_state: got col=%b kv=%b cn=%b val=%h held=%b, want col=1110 kv=0 cn=0 val=0 held=0",
                     col_n, key_valid, cancel, key_value, key_held);
        end
        @(negedge clk) reset_n = 1'b1;
        n = 0;
        while (col_n === 4'b1110 && n < 4 * SD) begin @(negedge clk); n++; end
        for (int k = 1; k <= 8; k++) begin
            bad = 1'b0;
            for (int j = 0; j < SD; j++) begin
                if (col_n !== ~(4'b0001 << (k % 4))) bad = 1'b1;
                @(negedge clk);
            end
            compared++;
            if (bad) begin
                mismatched++;
                $display("FAIL scan_order dwell %0d: got col=%b, required %b for %0d cycles",
                         k, col_n, ~(4'b0001 << (k % 4)), SD);
            end
        end
    endtask

    task automatic test_single_key();
        int n, start;
        clear_events();
        start = cyc;
        press_for(5, 40);
        @(negedge clk);
        compared++;
        if (key_held !== 1'b1) begin
            mismatched++;
            $display("FAIL held_at_release: got %b, required 1", key_held);
        end
        n = 1;
        while (key_held === 1'b1 && n < 40) begin @(negedge clk); n++; end
        compared++;
        if (n < DB || n > DB + 4) begin
            mismatched++;
            $display("FAIL held_fall_delay: got %0d cycles after release, required %0d..%0d", n, DB, DB + 4);
        end
        compared++;
        if (col_n !== 4'b1011) begin
            mismatched++;
            $display("FAIL resume_column: got %b, required 1011", col_n);
        end
        idle(20);
        compared++;
        if (ev_code.size() != 1 || ev_code[0] != 5) begin
            mismatched++;
            $display("FAIL single_key: got %0d events (first %0d), required one event 0x5",
                     ev_code.size(), ev_code.size() > 0 ? ev_code[0] : -1);
        end else begin
            compared++;
            if (ev_cyc[0] - start < DB + 1 || ev_cyc[0] - start > 4 * SD + DB + 6) begin
                mismatched++;
                $display("FAIL single_key_latency: got %0d cycles, required %0d..%0d",
                         ev_cyc[0] - start, DB + 1, 4 * SD + DB + 6);
            end
        end
    endtask

    task automatic test_cancel();
        clear_events();
        press_for(12, 40);
        idle(30);
        compared++;
        if (ev_code.size() != 1 || ev_code[0] != 16) begin
            mismatched++;
            $display("FAIL cancel_event: got %0d events (first %0d), required one cancel",
                     ev_code.size(), ev_code.size() > 0 ? ev_code[0] : -1);
        end
        compared++;
        if (key_value !== 4'h5) begin
            mismatched++;
            $display("FAIL cancel_keeps_value: got %h, required 5", key_value);
        end
    endtask

    task automatic test_back_to_back();
        int keys[$];
        int exp[$];
        clear_events();
        keys = '{0, 1, 2, 4};
        for (int i = 0; i < 8; i++) keys.push_back(int'($urandom_range(0, 15)));
        foreach (keys[i]) begin
            press_for(keys[i], 40 + int'($urandom_range(0, 20)));
            idle(30 + int'($urandom_range(0, 20)));
            exp.push_back(code_of(keys[i]));
        end
        compared++;
        if (ev_code.size() != exp.size()) begin
            mismatched++;
            $display("FAIL sequence_count: got %0d events, required %0d", ev_code.size(), exp.size());
        end else begin
            foreach (exp[i]) begin
                compared++;
                if (ev_code[i] != exp[i]) begin
                    mismatched++;
                    $display("FAIL sequence_value[%0d]: got %0d, required %0d (16 = cancel)", i, ev_code[i], exp[i]);
                end
            end
        end
        compared++;
        if (consec_cnt != 0 || both_cnt != 0) begin
            mismatched++;
            $display("FAIL pulse_spacing: got %0d consecutive and %0d overlapping pulses, required 0 and 0",
                     consec_cnt, both_cnt);
        end
    endtask

    task automatic test_bounce();
        clear_events();
        press_for(9, 3);
        idle(2);
        press_for(9, 40);
        idle(30);
        compared++;
        if (ev_code.size() != 1 || ev_code[0] != 8) begin
            mismatched++;
            $display("FAIL bounce: got %0d events (first %0d), required one event 0x8",
                     ev_code.size(), ev_code.size() > 0 ? ev_code[0] : -1);
        end
    endtask

    task automatic test_multi_key();
        int n;
        clear_events();
        @(posedge clk); #2 pressed[1] = 1'b1; pressed[5] = 1'b1;
        idle(50);
        compared++;
        if (ev_code.size() != 0 || key_held !== 1'b0) begin
            mismatched++;
            $display("FAIL same_column_pair: got %0d events held=%b, required 0 events held=0",
                     ev_code.size(), key_held);
        end
        #2 pressed[1] = 1'b0; pressed[5] = 1'b0;
        idle(30);
        @(posedge clk); #2 pressed[8] = 1'b1;
        n = 0;
        while (key_held !== 1'b1 && n < 60) begin @(negedge clk); n++; end
        compared++;
        if (n >= 60) begin
            mismatched++;
            $display("FAIL hold_seven: key_held got 0 after %0d cycles, required 1", n);
        end
        press_for(10, 10);
        idle(5);
        #2 pressed[8] = 1'b0;
        idle(40);
        compared++;
        if (ev_code.size() != 1 || ev_code[0] != 7) begin
            mismatched++;
            $display("FAIL no_rollover: got %0d events (first %0d), required one event 0x7",
                     ev_code.size(), ev_code.size() > 0 ? ev_code[0] : -1);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        clear_events();
        @(posedge clk); #2 pressed[13] = 1'b1;
        @(negedge clk);
        n = 0;
        while (col_n === 4'b1101 && n < 20) begin @(negedge clk); n++; end
        n = 0;
        while (col_n !== 4'b1101 && n < 20) begin @(negedge clk); n++; end
        repeat (SD + 3) @(negedge clk);
        compared++;
        if (col_n !== 4'b1101 || ev_code.size() != 0) begin
            mismatched++;
            $display("FAIL debounce_hold: got col=%b events=%0d, required col=1101 events=0",
                     col_n, ev_code.size());
        end
        reset_n = 1'b0;
        #1;
        compared++;
        if ({col_n, key_valid, cancel, key_value, key_held} !== {4'b1110, 1'b0, 1'b0, 4'h0, 1'b0}) begin
            mismatched++;
            $display("FAIL async_reset: got col=%b kv=%b cn=%b val=%h held=%b, want col=1110 kv=0 cn=0 val=0 held=0",
                     col_n, key_valid, cancel, key_value, key_held);
        end
        idle(3);
        @(negedge clk) reset_n = 1'b1;
        idle(50);
        #2 pressed[13] = 1'b0;
        idle(30);
        compared++;
        if (ev_code.size() != 1 || ev_code[0] != 0) begin
            mismatched++;
            $display("FAIL reset_then_zero: got %0d events (first %0d), required one event 0x0",
                     ev_code.size(), ev_code.size() > 0 ? ev_code[0] : -1);
        end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_cancel();
        test_back_to_back();
        test_bounce();
        test_multi_key();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

endmodule
